cg_write_scheduler: RTL and testbench

// - Shares one write-data path among NREQ requesters, each owning one enable-gated register group.
// - Round-robin arbitration produces one-hot per-group write enables (EN) plus the muxed write data (D_OUT).
// - Each group also gets a clock-gate enable (CG_EN) with wake-up settle time and idle-timeout sleep.
// - Sits between the requester logic and the gated register banks plus their ICG cells.

---
 rtl/cg_sched_pkg.sv | 21 ++
 rtl/cg_write_scheduler_group_fsm.sv | 81 ++++++++
 rtl/cg_write_scheduler.sv | 94 +++++++++
 tb/tb_cg_write_scheduler.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/cg_sched_pkg.sv
// Shared types and helpers for the clock-gated write scheduler.
// Holds the per-group state encoding and the counter-width helpers.
package cg_sched_pkg;

    typedef enum logic [1:0] {
        SLEEP  = 2'd0,
        WAKE   = 2'd1,
        ACTIVE = 2'd2
    } grp_state_e;

    // Width of a counter that must represent 0..wake_cyc
    function automatic int unsigned wake_cnt_w(input int unsigned wake_cyc);
        return (wake_cyc < 1) ? 1 : $clog2(wake_cyc + 1);
    endfunction

    // Width of a counter that must represent 0..idle_cyc
    function automatic int unsigned idle_cnt_w(input int unsigned idle_cyc);
        return (idle_cyc < 1) ? 1 : $clog2(idle_cyc + 1);
    endfunction

endpackage

// File: rtl/cg_write_scheduler_group_fsm.sv
// Per-group clock-gate controller: SLEEP -> WAKE (settle) -> ACTIVE -> idle timeout -> SLEEP.
// Drives the group's registered clock-gate enable and its arbitration eligibility.
module cg_group_fsm
    import cg_sched_pkg::*;
#(
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic gnt,
    output logic cg_en,
    output logic eligible,
    output logic awake_next
);

    localparam int unsigned WCW = wake_cnt_w(WAKE_CYC);
    localparam int unsigned ICW = idle_cnt_w(IDLE_CYC);
    localparam logic [WCW-1:0] WAKE_LAST = WCW'(WAKE_CYC - 1);
    localparam logic [ICW-1:0] IDLE_LAST = ICW'(IDLE_CYC - 1);

    grp_state_e     state_q, state_d;
    logic [WCW-1:0] wake_cnt_q, wake_cnt_d;
    logic [ICW-1:0] idle_cnt_q, idle_cnt_d;
    logic           cg_en_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SLEEP;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            cg_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wake_cnt_q <= wake_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            cg_en_q    <= (state_d != SLEEP);
        end
    end

    always_comb begin
        state_d    = state_q;
        wake_cnt_d = wake_cnt_q;
        idle_cnt_d = idle_cnt_q;
        unique case (state_q)
            SLEEP: begin
                if (req) begin
                    state_d    = WAKE;
                    wake_cnt_d = '0;
                end
            end
            WAKE: begin
                if (wake_cnt_q == WAKE_LAST) begin
                    state_d    = ACTIVE;
                    idle_cnt_d = '0;
                end else begin
                    wake_cnt_d = wake_cnt_q + 1'b1;
                end
            end
            ACTIVE: begin
                // A request arriving on the expiry edge keeps the group awake
                if (req || gnt) begin
                    idle_cnt_d = '0;
                end else if (idle_cnt_q == IDLE_LAST) begin
                    state_d = SLEEP;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            default: state_d = SLEEP;
        endcase
    end

    always_comb begin
        cg_en      = cg_en_q;
        eligible   = (state_q == ACTIVE) && req && !gnt;
        awake_next = (state_d != SLEEP);
    end

endmodule

// File: rtl/cg_write_scheduler.sv
// Round-robin write scheduler sharing one data path among NREQ clock-gated register groups.
// Registers the one-hot grant, the winner's data and the aggregate busy flag.
module cg_write_scheduler
    import cg_sched_pkg::*;
#(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned W        = 1,
    parameter int unsigned WAKE_CYC = 2,
    parameter int unsigned IDLE_CYC = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ*W-1:0] D_IN,
    output logic [NREQ-1:0]   GNT,
    output logic [NREQ-1:0]   EN,
    output logic [W-1:0]      D_OUT,
    output logic [NREQ-1:0]   CG_EN,
    output logic              BUSY
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] awake_next;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]    dout_q;
    logic [PW-1:0]   ptr_q, ptr_next;
    logic [PW-1:0]   win;
    logic            found;
    logic            busy_q;
    logic [W-1:0]    d_sel;

    for (genvar i = 0; i < NREQ; i++) begin : g_grp
        cg_group_fsm #(
            .WAKE_CYC(WAKE_CYC),
            .IDLE_CYC(IDLE_CYC)
        ) u_fsm (
            .clk       (CLK),
            .rst       (RST),
            .req       (REQ[i]),
            .gnt       (gnt_q[i]),
            .cg_en     (CG_EN[i]),
            .eligible  (eligible[i]),
            .awake_next(awake_next[i])
        );
    end

    // Search from the round-robin pointer; the first eligible index wins
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            idx = (int'(ptr_q) + k) % int'(NREQ);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt_d    = '0;
        gnt_d    = NREQ'(1) << win;
        ptr_next = (int'(win) == int'(NREQ) - 1) ? '0 : win + 1'b1;
        d_sel    = D_IN[int'(win)*int'(W) +: W];
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            gnt_q  <= '0;
            dout_q <= '0;
            ptr_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            busy_q <= |awake_next;
            if (found) begin
                gnt_q  <= gnt_d;
                dout_q <= d_sel;
                ptr_q  <= ptr_next;
            end else begin
                gnt_q  <= '0;
            end
        end
    end

    assign GNT   = gnt_q;
    assign EN    = gnt_q;
    assign D_OUT = dout_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_cg_write_scheduler.sv
// Self-checking bench for cg_write_scheduler: directed scenarios plus randomized traffic
// compared every cycle against a timestamp-based reference model.
module tb_cg_write_scheduler;

    localparam int NREQ     = 4;
    localparam int W        = 1;
    localparam int WAKE_CYC = 2;
    localparam int IDLE_CYC = 4;

    logic             CLK = 1'b0;
    logic             RST;
    logic [NREQ-1:0]  REQ;
    logic [NREQ*W-1:0] D_IN;
    logic [NREQ-1:0]  GNT;
    logic [NREQ-1:0]  EN;
    logic [W-1:0]     D_OUT;
    logic [NREQ-1:0]  CG_EN;
    logic             BUSY;

    cg_write_scheduler #(
        .NREQ(NREQ),
        .W(W),
        .WAKE_CYC(WAKE_CYC),
        .IDLE_CYC(IDLE_CYC)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .REQ  (REQ),
        .D_IN (D_IN),
        .GNT  (GNT),
        .EN   (EN),
        .D_OUT(D_OUT),
        .CG_EN(CG_EN),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model: a group is awake from the edge it woke, usable WAKE_CYC edges later,
    // and falls asleep IDLE_CYC edges after its last activity (request or grant) while usable.
    int              n;
    int              awake_edge [NREQ];
    int              anchor     [NREQ];
    logic [NREQ-1:0] m_gnt;
    logic [W-1:0]    m_dout;
    int              m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (model edge %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) begin
            awake_edge[i] = -1;
            anchor[i]     = 0;
        end
        m_gnt  = '0;
        m_dout = '0;
        m_ptr  = 0;
        n      = 0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] usable;
        logic [NREQ-1:0] g_old;
        int              win;
        int              idx;
        n++;
        g_old = m_gnt;
        win   = -1;
        for (int i = 0; i < NREQ; i++)
            usable[i] = (awake_edge[i] >= 0) && ((n - 1) >= awake_edge[i] + WAKE_CYC);
        for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && usable[idx] && REQ[idx] && !g_old[idx]) win = idx;
        end
        m_gnt = '0;
        if (win >= 0) begin
            m_gnt[win] = 1'b1;
            m_dout     = D_IN[win*W +: W];
            m_ptr      = (win + 1) % NREQ;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (awake_edge[i] < 0) begin
                if (REQ[i]) begin
                    awake_edge[i] = n;
                    anchor[i]     = n + WAKE_CYC;
                end
            end else if (usable[i]) begin
                if (REQ[i] || g_old[i]) anchor[i] = n;
                else if (n - anchor[i] >= IDLE_CYC) awake_edge[i] = -1;
            end
        end
    endtask

    task automatic compare_model();
        logic [NREQ-1:0] exp_cg;
        for (int i = 0; i < NREQ; i++) exp_cg[i] = (awake_edge[i] >= 0);
        chk("gnt", 32'(GNT), 32'(m_gnt));
        chk("en", 32'(EN), 32'(m_gnt));
        chk("d_out", 32'(D_OUT), 32'(m_dout));
        chk("cg_en", 32'(CG_EN), 32'(exp_cg));
        chk("busy", 32'(BUSY), 32'(|exp_cg));
        chk("gnt_onehot", 32'($countones(GNT) <= 1), 32'd1);
        chk("cg_covers_gnt", 32'(GNT & ~CG_EN), 32'd0);
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        compare_model();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(GNT), 32'd0);
        chk({tag, "_en"}, 32'(EN), 32'd0);
        chk({tag, "_dout"}, 32'(D_OUT), 32'd0);
        chk({tag, "_cg_en"}, 32'(CG_EN), 32'd0);
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] rr_gnt [8];
        logic [W-1:0]    rr_dout[8];
        rr_gnt  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dout = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        RST  = 1'b0;
        REQ  = '0;
        D_IN = '0;
        model_reset();
        #2 RST = 1'b1;
        #1 chk_all_zero("por");
        @(posedge CLK);
        #1 RST = 1'b0;

        // Round robin from cold: all four wake together, then rotate 0,1,2,3,0
        REQ  = 4'b1111;
        D_IN = 4'b1010;
        for (int t = 0; t < 8; t++) begin
            tick();
            chk($sformatf("rr_gnt_t%0d", t + 1), 32'(GNT), 32'(rr_gnt[t]));
            if (t >= 3) chk($sformatf("rr_dout_t%0d", t + 1), 32'(D_OUT), 32'(rr_dout[t]));
            if (t == 0) chk("rr_cg_en_t1", 32'(CG_EN), 32'hf);
        end

        // Reset mid-run: outputs clear without waiting for a clock edge
        RST = 1'b1;
        REQ = '0;
        #1 chk_all_zero("midrst");
        @(posedge CLK);
        #1 chk_all_zero("midrst_hold");
        RST = 1'b0;
        model_reset();

        // Cold wake of group 0, then idle sleep
        REQ  = 4'b0001;
        D_IN = 4'b0001;
        for (int t = 1; t <= 4; t++) begin
            tick();
            if (t == 1) chk("cold_cg_en_t1", 32'(CG_EN[0]), 32'd1);
            if (t < 4) chk($sformatf("cold_gnt_t%0d", t), 32'(GNT), 32'd0);
        end
        chk("cold_gnt_t4", 32'(GNT), 32'b0001);
        chk("cold_en_t4", 32'(EN), 32'b0001);
        chk("cold_dout_t4", 32'(D_OUT), 32'd1);
        REQ = '0;
        for (int t = 5; t <= 9; t++) begin
            tick();
            if (t == 5) chk("cold_no_regrant", 32'(GNT), 32'd0);
            chk($sformatf("idle_cg_en0_t%0d", t), 32'(CG_EN[0]), (t < 9) ? 32'd1 : 32'd0);
        end
        chk("idle_busy", 32'(BUSY), 32'd0);

        // Hot path on group 2
        REQ = 4'b0100;
        for (int t = 0; t < 4; t++) tick();
        chk("hot_wake_gnt", 32'(GNT), 32'b0100);
        REQ = '0;
        tick();
        REQ = 4'b0100;
        tick();
        chk("hot_gnt", 32'(GNT), 32'b0100);
        REQ = '0;
        tick();
        chk("hot_single_a", 32'(GNT), 32'd0);
        tick();
        chk("hot_single_b", 32'(GNT), 32'd0);

        // Race: request lands on the edge where group 1 would time out
        REQ = 4'b0010;
        for (int t = 0; t < 4; t++) tick();
        chk("race_first_gnt", 32'(GNT), 32'b0010);
        REQ = '0;
        for (int t = 0; t < 4; t++) tick();
        chk("race_pre_cg", 32'(CG_EN[1]), 32'd1);
        REQ = 4'b0010;
        tick();
        chk("race_gnt", 32'(GNT), 32'b0010);
        chk("race_cg", 32'(CG_EN[1]), 32'd1);
        REQ = '0;
        tick();
        chk("race_cg_after", 32'(CG_EN[1]), 32'd1);

        // Randomized traffic: requesters hold until granted, with occasional early drops
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (REQ[i] && GNT[i]) REQ[i] = 1'b0;
                else if (REQ[i] && $urandom_range(0, 31) == 0) REQ[i] = 1'b0;
                else if (!REQ[i] && $urandom_range(0, (c < 300) ? 3 : 15) == 0) REQ[i] = 1'b1;
            end
            D_IN = NREQ'($urandom);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
